// File: rtl/i2c_transaction_sequencer_if.sv
// Request, response and byte-engine command signals of the I2C transaction sequencer.
// master = sequencer side, slave = requester/engine side.
interface i2c_transaction_sequencer_if #(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = 3
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_read;
  logic [6:0]             req_dev_addr;
  logic [7:0]             req_reg_addr;
  logic [LEN_W-1:0]       req_len;
  logic [8*MAX_LEN-1:0]   req_wdata;
  logic [2:0]             eng_cmd;
  logic                   eng_cmd_valid;
  logic                   eng_cmd_ready;
  logic [7:0]             eng_wdata;
  logic                   eng_done;
  logic [7:0]             eng_rdata;
  logic                   eng_nack;
  logic                   eng_timeout;
  logic                   rsp_valid;
  logic [1:0]             rsp_status;
  logic [8*MAX_LEN-1:0]   rsp_data;
  logic                   busy;

  modport master (
    input  req_valid, req_read, req_dev_addr, req_reg_addr, req_len, req_wdata,
           eng_cmd_ready, eng_done, eng_rdata, eng_nack, eng_timeout,
    output req_ready, eng_cmd, eng_cmd_valid, eng_wdata, rsp_valid, rsp_status,
           rsp_data, busy
  );

  modport slave (
    output req_valid, req_read, req_dev_addr, req_reg_addr, req_len, req_wdata,
           eng_cmd_ready, eng_done, eng_rdata, eng_nack, eng_timeout,
    input  req_ready, eng_cmd, eng_cmd_valid, eng_wdata, rsp_valid, rsp_status,
           rsp_data, busy
  );
endinterface

// File: rtl/i2c_transaction_sequencer.sv
// Sequences I2C register read/write/probe transactions over a byte-level engine.
// Define I2C_SEQ_RETRY_EN to restart the transaction on address NACK (up to RETRY_MAX times).
module i2c_transaction_sequencer #(
  parameter int MAX_LEN   = 4,
  parameter int LEN_W     = 3,
  parameter int RETRY_MAX = 3
) (
  input logic clock,
  input logic reset_n,
  i2c_transaction_sequencer_if.master bus
);
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int RCNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [2:0] CMD_START = 3'd0, CMD_WRITE = 3'd1, CMD_RACK = 3'd2,
                         CMD_RNACK = 3'd3, CMD_STOP  = 3'd4, CMD_RESTART = 3'd5;
  localparam logic [1:0] ST_OK = 2'b00, ST_ANACK = 2'b01, ST_DNACK = 2'b10, ST_TOUT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_REG, S_RESTART, S_DEVR, S_RDATA, S_WDATA, S_STOP, S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 gap_q, gap_d;
  logic [LEN_W-1:0]     idx_q, idx_d, len_q, len_d;
  logic                 read_q, read_d;
  logic [6:0]           dev_q, dev_d;
  logic [7:0]           reg_q, reg_d;
  logic [8*MAX_LEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]           status_q, status_d;
  logic [RCNT_W-1:0]    retry_q, retry_d;
  logic                 again_q, again_d;

  logic       is_cmd, fire, cmpl, last, retry_ok;
  logic [2:0] cmd;
  logic [7:0] wbyte, wsel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      gap_q    <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
      read_q   <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
      retry_q  <= '0;
      again_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      read_q   <= read_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      retry_q  <= retry_d;
      again_q  <= again_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    gap_d    = 1'b0;
    idx_d    = idx_q;
    len_d    = len_q;
    read_d   = read_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    retry_d  = retry_q;
    again_d  = again_q;
    is_cmd   = 1'b0;
    cmd      = CMD_START;
    wbyte    = 8'h00;
    last     = (idx_q == len_q - LEN_W'(1));
    retry_ok = RETRY_EN && (int'(retry_q) < RETRY_MAX);
    wsel     = 8'h00;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx_q == LEN_W'(i)) wsel = wdata_q[8*i +: 8];

    case (state_q)
      S_START:   begin is_cmd = 1'b1; cmd = CMD_START; end
      S_DEVW:    begin is_cmd = 1'b1; cmd = CMD_WRITE; wbyte = {dev_q, 1'b0}; end
      S_REG:     begin is_cmd = 1'b1; cmd = CMD_WRITE; wbyte = reg_q; end
      S_RESTART: begin is_cmd = 1'b1; cmd = CMD_RESTART; end
      S_DEVR:    begin is_cmd = 1'b1; cmd = CMD_WRITE; wbyte = {dev_q, 1'b1}; end
      S_RDATA:   begin is_cmd = 1'b1; cmd = last ? CMD_RNACK : CMD_RACK; end
      S_WDATA:   begin is_cmd = 1'b1; cmd = CMD_WRITE; wbyte = wsel; end
      S_STOP:    begin is_cmd = 1'b1; cmd = CMD_STOP; end
      default:   ;
    endcase

    // A done coinciding with the ready handshake is consumed now; gap_q keeps the
    // next command's valid low for one cycle so valid always drops after ready.
    fire = is_cmd && !pend_q && !gap_q && bus.eng_cmd_ready;
    if (fire) pend_d = 1'b1;
    cmpl = (fire || pend_q) && bus.eng_done;

    if (cmpl) begin
      pend_d = 1'b0;
      gap_d  = fire;
      if (bus.eng_timeout) begin
        status_d = ST_TOUT;
        state_d  = S_RESP;
      end else begin
        case (state_q)
          S_START: state_d = S_DEVW;
          S_DEVW, S_DEVR: begin
            if (bus.eng_nack) begin
              state_d = S_STOP;
              if (retry_ok) begin
                again_d = 1'b1;
                retry_d = retry_q + RCNT_W'(1);
              end else begin
                status_d = ST_ANACK;
              end
            end else if (state_q == S_DEVR) begin
              state_d = S_RDATA;
              idx_d   = '0;
            end else if (len_q == '0) begin
              state_d = S_STOP;
            end else begin
              state_d = S_REG;
            end
          end
          S_REG: begin
            if (bus.eng_nack) begin
              status_d = ST_DNACK;
              state_d  = S_STOP;
            end else if (read_q) begin
              state_d = S_RESTART;
            end else begin
              state_d = S_WDATA;
              idx_d   = '0;
            end
          end
          S_RESTART: state_d = S_DEVR;
          S_RDATA: begin
            for (int i = 0; i < MAX_LEN; i++)
              if (idx_q == LEN_W'(i)) rdata_d[8*i +: 8] = bus.eng_rdata;
            if (last) state_d = S_STOP;
            else      idx_d   = idx_q + LEN_W'(1);
          end
          S_WDATA: begin
            if (bus.eng_nack) begin
              status_d = ST_DNACK;
              state_d  = S_STOP;
            end else if (last) begin
              state_d = S_STOP;
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
          S_STOP: begin
            if (again_q) begin
              again_d = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_RESP;
            end
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d  = S_START;
          read_d   = bus.req_read;
          dev_d    = bus.req_dev_addr;
          reg_d    = bus.req_reg_addr;
          len_d    = (bus.req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.req_len;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          status_d = ST_OK;
          retry_d  = '0;
          again_d  = 1'b0;
          idx_d    = '0;
          pend_d   = 1'b0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: ;
    endcase
  end

  assign bus.eng_cmd       = cmd;
  assign bus.eng_wdata     = wbyte;
  assign bus.eng_cmd_valid = is_cmd && !pend_q && !gap_q;
  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_status    = (state_q == S_RESP) ? status_q : ST_OK;
  assign bus.rsp_data      = rdata_q;
endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Randomized bench for i2c_transaction_sequencer: a transaction-level model predicts the
// engine command list, the per-command engine replies, the final status and the read data.
module tb_i2c_transaction_sequencer;
  localparam int MAX_LEN = 4, LEN_W = 3, RETRY_MAX = 3;
  localparam int C_START = 0, C_WR = 1, C_RA = 2, C_RN = 3, C_STOP = 4, C_RS = 5;
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  i2c_transaction_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus();
  i2c_transaction_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RETRY_MAX(RETRY_MAX)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int          exp_cmd[$];
  bit          r_nack[$], r_tout[$];
  logic [7:0]  r_data[$];
  int          exp_status;
  logic [31:0] exp_data;
  int          m_anacks, m_dnack_at, m_tout_at, m_dw, m_rd;
  logic [7:0]  m_rb[4];

  // observations of one transaction
  int          got_cmd[$];
  int          got_status, viol;
  logic [31:0] got_data;
  bit          got_rsp, post_ok, accept_ok, abort_ok1, abort_ok2;

  // kind: 0 control, 1 address byte, 2 register/payload byte, 3 read
  task automatic issue(input int cmd, input int b, input int kind, output int res);
    bit n, t;
    logic [7:0] r;
    n = 1'b0;
    r = 8'h00;
    t = (exp_cmd.size() == m_tout_at);
    if (kind == 1 && m_anacks > 0) begin n = 1'b1; m_anacks--; end
    if (kind == 2) begin n = (m_dw == m_dnack_at); m_dw++; end
    if (t && (kind == 1 || kind == 2) && $urandom_range(0, 1) == 1) n = 1'b1;
    if (kind == 3) begin
      r = m_rb[m_rd % 4];
      if (!t) exp_data[8*m_rd +: 8] = r;
      m_rd++;
    end
    exp_cmd.push_back(cmd * 256 + ((cmd == C_WR) ? b : 0));
    r_nack.push_back(n);
    r_tout.push_back(t);
    r_data.push_back(r);
    res = t ? 2 : (n ? 1 : 0);
  endtask

  task automatic build_model(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                             input int len_in, input logic [31:0] wd,
                             input int anacks, input int dnack, input int tout);
    int len, retries, r, st;
    exp_cmd.delete(); r_nack.delete(); r_tout.delete(); r_data.delete();
    exp_data = '0;
    m_anacks = anacks; m_dnack_at = dnack; m_tout_at = tout; m_dw = 0;
    len = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    retries = 0;
    forever begin
      st = -1;   // -1 running, 0 ok, 1 address NACK, 2 data NACK, 3 timeout
      m_rd = 0;
      issue(C_START, 0, 0, r);
      if (r == 2) st = 3;
      if (st < 0) begin
        issue(C_WR, {dev, 1'b0}, 1, r);
        if (r == 2) st = 3; else if (r == 1) st = 1; else if (len == 0) st = 0;
      end
      if (st < 0) begin
        issue(C_WR, rg, 2, r);
        if (r == 2) st = 3; else if (r == 1) st = 2;
      end
      if (st < 0 && rd) begin
        issue(C_RS, 0, 0, r);
        if (r == 2) st = 3;
        if (st < 0) begin
          issue(C_WR, {dev, 1'b1}, 1, r);
          if (r == 2) st = 3; else if (r == 1) st = 1;
        end
      end
      for (int i = 0; i < len && st < 0; i++) begin
        if (rd) begin
          issue((i == len - 1) ? C_RN : C_RA, 0, 3, r);
          if (r == 2) st = 3;
        end else begin
          issue(C_WR, wd[8*i +: 8], 2, r);
          if (r == 2) st = 3; else if (r == 1) st = 2;
        end
      end
      if (st < 0) st = 0;
      if (st == 3) begin exp_status = 3; return; end
      issue(C_STOP, 0, 0, r);
      if (r == 2) begin exp_status = 3; return; end
      if (st == 1 && RETRY_EN && retries < RETRY_MAX) begin
        retries++;
        continue;
      end
      exp_status = st;
      return;
    end
  endtask

  task automatic respond(input int idx);
    bus.eng_done = 1'b1;
    if (idx < r_nack.size()) begin
      bus.eng_nack    = r_nack[idx];
      bus.eng_timeout = r_tout[idx];
      bus.eng_rdata   = r_data[idx];
    end
  endtask

  // Drives one request and plays the engine from the model's reply table.
  task automatic run_txn(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                         input int len, input logic [31:0] wd,
                         input int stall, input bit poke, input int abort_at);
    int k, ddly, stall_left;
    bit outstanding, seen, drop_chk, poked;
    logic [2:0] hold_cmd;
    logic [7:0] hold_wd;
    got_cmd.delete();
    got_rsp = 0; post_ok = 0; viol = 0; got_status = -1; got_data = '0;
    k = 0; ddly = 0; stall_left = 0; outstanding = 0; seen = 0; drop_chk = 0; poked = 0;
    hold_cmd = '0; hold_wd = '0;
    bus.req_valid = 1'b1; bus.req_read = rd; bus.req_dev_addr = dev; bus.req_reg_addr = rg;
    bus.req_len = len[LEN_W-1:0]; bus.req_wdata = wd;
    @(negedge clock);
    accept_ok = bus.req_ready === 1'b0 && bus.busy === 1'b1 && bus.eng_cmd_valid === 1'b1
                && bus.eng_cmd === 3'd0;
    bus.req_dev_addr = 7'($urandom); bus.req_reg_addr = 8'($urandom); bus.req_wdata = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.req_valid = 1'b0; bus.eng_cmd_ready = 1'b0; bus.eng_done = 1'b0;
      bus.eng_nack = 1'b0; bus.eng_timeout = 1'b0; bus.eng_rdata = 8'h00;
      if (abort_at > 0 && cyc == abort_at) begin
        reset_n = 1'b0;
        #1;
        abort_ok1 = {bus.req_ready, bus.busy, bus.eng_cmd_valid, bus.rsp_valid, bus.rsp_status,
                     bus.eng_cmd, bus.eng_wdata, bus.rsp_data} === {1'b1, 48'd0};
        @(posedge clock);
        #1;
        abort_ok2 = {bus.req_ready, bus.busy, bus.eng_cmd_valid, bus.rsp_valid, bus.rsp_status,
                     bus.eng_cmd, bus.eng_wdata, bus.rsp_data} === {1'b1, 48'd0};
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        return;
      end
      if (bus.rsp_valid === 1'b1) begin
        got_rsp = 1; got_status = int'(bus.rsp_status); got_data = bus.rsp_data;
        @(negedge clock);
        post_ok = bus.req_ready === 1'b1 && bus.busy === 1'b0 && bus.rsp_valid === 1'b0;
        return;
      end
      if (bus.req_ready !== 1'b0) viol++;
      if (drop_chk && bus.eng_cmd_valid !== 1'b0) viol++;
      drop_chk = 0;
      if (outstanding) begin
        if (bus.eng_cmd_valid !== 1'b0) viol++;
        ddly--;
        if (ddly <= 0) begin respond(k - 1); outstanding = 0; end
      end else if (bus.eng_cmd_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; hold_cmd = bus.eng_cmd; hold_wd = bus.eng_wdata;
          stall_left = (stall < 0) ? $urandom_range(0, 2) : stall;
        end else if (bus.eng_cmd !== hold_cmd || bus.eng_wdata !== hold_wd) begin
          viol++;
        end
        if (stall_left > 0) begin
          stall_left--;
          if (poke && k == 1 && !poked) begin
            poked = 1; bus.req_valid = 1'b1; bus.req_read = ~rd;
            bus.req_dev_addr = ~dev; bus.req_reg_addr = ~rg; bus.req_len = 3'd1;
          end
        end else begin
          bus.eng_cmd_ready = 1'b1;
          got_cmd.push_back(int'(bus.eng_cmd) * 256 + ((bus.eng_cmd == 3'd1) ? int'(bus.eng_wdata) : 0));
          k++; seen = 0; drop_chk = 1;
          ddly = $urandom_range(0, 2);
          if (ddly == 0) respond(k - 1); else outstanding = 1;
        end
      end
      @(negedge clock);
    end
  endtask

  function automatic int seq_diff();
    int n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) if (got_cmd[i] != exp_cmd[i]) return i;
    if (got_cmd.size() != exp_cmd.size()) return n;
    return -1;
  endfunction

  function automatic int count_starts();
    int c = 0;
    foreach (got_cmd[i]) if (got_cmd[i] == C_START * 256) c++;
    return c;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({bus.req_ready, bus.busy, bus.eng_cmd_valid, bus.rsp_valid, bus.rsp_status, bus.eng_cmd,
         bus.eng_wdata, bus.rsp_data} !== {1'b1, 48'd0}) begin
      n_fail++; $display("FAIL reset_in: ready=%b busy=%b cvalid=%b rvalid=%b, required 1 0 0 0",
                         bus.req_ready, bus.busy, bus.eng_cmd_valid, bus.rsp_valid);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({bus.req_ready, bus.busy, bus.eng_cmd_valid, bus.rsp_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_out: ready=%b busy=%b cvalid=%b rvalid=%b, required 1 0 0 0",
                         bus.req_ready, bus.busy, bus.eng_cmd_valid, bus.rsp_valid);
    end
  endtask

  task automatic test_write();
    int d;
    build_model(0, 7'h68, 8'h0E, 2, 32'h0000_1C00, 0, -1, -1);
    run_txn(0, 7'h68, 8'h0E, 2, 32'h0000_1C00, 0, 0, 0);
    d = seq_diff();
    n_tests++;
    if (d >= 0 || got_cmd.size() != 6 || got_cmd[4] != C_WR * 256 + 8'h1C) begin
      n_fail++; $display("FAIL write_seq: got %0d cmds, required 6 (first difference at %0d)",
                         got_cmd.size(), d);
    end
    n_tests++;
    if (!got_rsp || got_status != 0) begin
      n_fail++; $display("FAIL write_status: got %0d (rsp=%0b), required 0", got_status, got_rsp);
    end
    n_tests++;
    if (!accept_ok || !post_ok || viol != 0) begin
      n_fail++; $display("FAIL write_handshake: accept=%0b post=%0b violations=%0d, required 1 1 0",
                         accept_ok, post_ok, viol);
    end
  endtask

  task automatic test_read();
    int d;
    m_rb[0] = 8'h45; m_rb[1] = 8'h30; m_rb[2] = 8'h12; m_rb[3] = 8'hEE;
    build_model(1, 7'h68, 8'h00, 3, 32'h0, 0, -1, -1);
    run_txn(1, 7'h68, 8'h00, 3, 32'h0, -1, 0, 0);
    d = seq_diff();
    n_tests++;
    if (d >= 0) begin
      n_fail++; $display("FAIL read_seq: got %0d cmds, required %0d (first difference at %0d)",
                         got_cmd.size(), exp_cmd.size(), d);
    end
    n_tests++;
    if (got_data !== 32'h0012_3045 || got_status != 0) begin
      n_fail++; $display("FAIL read_data: got %h status %0d, required 00123045 status 0",
                         got_data, got_status);
    end
  endtask

  task automatic test_addr_nack(input int anacks, input string name);
    int d, want_starts;
    build_model(0, 7'h68, 8'h0E, 1, 32'h5A, anacks, -1, -1);
    run_txn(0, 7'h68, 8'h0E, 1, 32'h5A, -1, 0, 0);
    d = seq_diff();
    want_starts = RETRY_EN ? ((anacks > RETRY_MAX) ? RETRY_MAX + 1 : anacks + 1) : 1;
    n_tests++;
    if (d >= 0 || count_starts() != want_starts) begin
      n_fail++; $display("FAIL %s_seq: got %0d cmds %0d starts, required %0d cmds %0d starts (diff at %0d)",
                         name, got_cmd.size(), count_starts(), exp_cmd.size(), want_starts, d);
    end
    n_tests++;
    if (got_status != ((RETRY_EN && anacks <= RETRY_MAX) ? 0 : 1) || got_status != exp_status) begin
      n_fail++; $display("FAIL %s_status: got %0d, required %0d", name, got_status, exp_status);
    end
  endtask

  task automatic test_timeout();
    int d;
    for (int i = 0; i < 4; i++) m_rb[i] = 8'($urandom_range(1, 255));
    build_model(1, 7'h68, 8'h03, 4, 32'h0, 0, -1, 6);
    run_txn(1, 7'h68, 8'h03, 4, 32'h0, -1, 0, 0);
    d = seq_diff();
    n_tests++;
    if (d >= 0 || got_cmd.size() == 0 || got_cmd[got_cmd.size() - 1] == C_STOP * 256) begin
      n_fail++; $display("FAIL timeout_seq: got %0d cmds, required %0d with no STOP (diff at %0d)",
                         got_cmd.size(), exp_cmd.size(), d);
    end
    n_tests++;
    if (got_status != 3 || got_data !== {24'h0, m_rb[0]}) begin
      n_fail++; $display("FAIL timeout_rsp: got status %0d data %h, required 3 data %h",
                         got_status, got_data, {24'h0, m_rb[0]});
    end
  endtask

  task automatic test_stall();
    int d;
    build_model(0, 7'h21, 8'h44, 3, 32'h00C3_B2A1, 0, -1, -1);
    run_txn(0, 7'h21, 8'h44, 3, 32'h00C3_B2A1, 5, 1, 0);
    d = seq_diff();
    n_tests++;
    if (viol != 0) begin
      n_fail++; $display("FAIL stall_stable: got %0d handshake violations, required 0", viol);
    end
    n_tests++;
    if (d >= 0 || got_status != exp_status) begin
      n_fail++; $display("FAIL stall_seq: got %0d cmds status %0d, required %0d cmds status %0d (diff at %0d)",
                         got_cmd.size(), got_status, exp_cmd.size(), exp_status, d);
    end
  endtask

  task automatic test_probe();
    int d;
    build_model(0, 7'h50, 8'h99, 0, 32'h0, 0, -1, -1);
    run_txn(0, 7'h50, 8'h99, 0, 32'h0, -1, 0, 0);
    d = seq_diff();
    n_tests++;
    if (d >= 0 || got_cmd.size() != 3 || got_cmd[1] != C_WR * 256 + 8'hA0 || got_status != 0) begin
      n_fail++; $display("FAIL probe: got %0d cmds status %0d, required 3 cmds status 0 (diff at %0d)",
                         got_cmd.size(), got_status, d);
    end
  endtask

  task automatic test_data_nack();
    int d;
    build_model(0, 7'h3C, 8'h10, 7, 32'h4433_2211, 0, 2, -1);
    run_txn(0, 7'h3C, 8'h10, 7, 32'h4433_2211, -1, 0, 0);
    d = seq_diff();
    n_tests++;
    if (d >= 0 || got_status != 2) begin
      n_fail++; $display("FAIL data_nack: got %0d cmds status %0d, required %0d cmds status 2 (diff at %0d)",
                         got_cmd.size(), got_status, exp_cmd.size(), d);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    for (int i = 0; i < 4; i++) m_rb[i] = 8'($urandom);
    build_model(1, 7'h68, 8'h00, 4, 32'h0, 0, -1, -1);
    abort_ok1 = 0; abort_ok2 = 0;
    run_txn(1, 7'h68, 8'h00, 4, 32'h0, 0, 0, 14);
    n_tests++;
    if (!abort_ok1 || !abort_ok2) begin
      n_fail++; $display("FAIL reset_mid: reset values at assert=%0b next cycle=%0b, required 1 1",
                         abort_ok1, abort_ok2);
    end
    build_model(0, 7'h11, 8'h22, 1, 32'h33, 0, -1, -1);
    run_txn(0, 7'h11, 8'h22, 1, 32'h33, -1, 0, 0);
    d = seq_diff();
    n_tests++;
    if (d >= 0 || got_status != 0) begin
      n_fail++; $display("FAIL reset_recover: got %0d cmds status %0d, required %0d cmds status 0",
                         got_cmd.size(), got_status, exp_cmd.size());
    end
  endtask

  task automatic test_back_to_back();
    int d, anacks, dn, to, len;
    bit rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [31:0] wd;
    for (int t = 0; t < 30; t++) begin
      rd = 1'($urandom); dev = 7'($urandom); rg = 8'($urandom); wd = $urandom;
      len = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0: anacks = 1;
        1: anacks = 2;
        2: anacks = 6;
        default: anacks = 0;
      endcase
      dn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
      to = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : -1;
      for (int i = 0; i < 4; i++) m_rb[i] = 8'($urandom);
      build_model(rd, dev, rg, len, wd, anacks, dn, to);
      run_txn(rd, dev, rg, len, wd, -1, 1'($urandom), 0);
      d = seq_diff();
      n_tests++;
      if (d >= 0) begin
        n_fail++; $display("FAIL rand%0d_seq: got %0d cmds, required %0d (first difference at %0d)",
                           t, got_cmd.size(), exp_cmd.size(), d);
      end
      n_tests++;
      if (!got_rsp || got_status != exp_status || got_data !== exp_data) begin
        n_fail++; $display("FAIL rand%0d_rsp: got status %0d data %h, required status %0d data %h",
                           t, got_status, got_data, exp_status, exp_data);
      end
      n_tests++;
      if (!accept_ok || !post_ok || viol != 0) begin
        n_fail++; $display("FAIL rand%0d_handshake: accept=%0b post=%0b violations=%0d, required 1 1 0",
                           t, accept_ok, post_ok, viol);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_dev_addr = '0; bus.req_reg_addr = '0;
    bus.req_len = '0; bus.req_wdata = '0; bus.eng_cmd_ready = 1'b0; bus.eng_done = 1'b0;
    bus.eng_rdata = '0; bus.eng_nack = 1'b0; bus.eng_timeout = 1'b0;
    for (int i = 0; i < 4; i++) m_rb[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_addr_nack(100, "addr_nack");
    test_addr_nack(1, "addr_nack_once");
    test_timeout();
    test_stall();
    test_probe();
    test_data_nack();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_transaction_sequencer.md
Name: i2c_transaction_sequencer

Overview:
- Sequences complete I2C register transactions over the shared byte-level I2C master engine (start/stop, byte write, byte read with ACK/NACK).
- Accepts one request at a time: device address, register address, and a write payload or read length.
- Issues the engine command sequence and returns read data plus a completion status.
- Sits between the clock application logic (RTC access) and the I2C engine.

Parameters:
- MAX_LEN, 4: maximum payload bytes per transaction.
- LEN_W, 3: width of req_len; must satisfy 2**LEN_W > MAX_LEN.
- RETRY_MAX, 3: address-NACK retries. Used only with I2C_SEQ_RETRY_EN.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, can accept a request
- req_read  in  1  1 = register read, 0 = register write
- req_dev_addr  in  7  7-bit slave address
- req_reg_addr  in  8  register pointer
- req_len  in  LEN_W  payload byte count, 0..MAX_LEN
- req_wdata  in  8*MAX_LEN  write payload; byte 0 = bits [7:0], sent first
- eng_cmd  out  3  0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP, 5 RESTART
- eng_cmd_valid  out  1  command valid
- eng_cmd_ready  in  1  engine accepts command
- eng_wdata  out  8  byte for WRITE
- eng_done  in  1  one-cycle pulse when the command completes
- eng_rdata  in  8  read byte, valid with eng_done
- eng_nack  in  1  slave NACKed the WRITE, valid with eng_done
- eng_timeout  in  1  clock-stretch timeout, valid with eng_done
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  2  00 OK, 01 address NACK, 10 data NACK, 11 timeout
- rsp_data  out  8*MAX_LEN  read bytes; byte 0 at [7:0]
- busy  out  1  transaction in progress

Behaviour:
- Reset values:
  - req_ready = 1; all other outputs 0.
  - FSM in IDLE; byte index 0.
  - Reset mid-transaction aborts immediately with no STOP issued. The engine shares reset_n and releases the bus itself.
- Accept: in IDLE, req_valid && req_ready latches all request fields.
  - Next cycle: req_ready = 0, busy = 1, START presented.
  - Request inputs are ignored while busy.
- Command handshake: only one command outstanding at a time.
  - eng_cmd, eng_cmd_valid and eng_wdata are held stable until eng_cmd_ready is sampled high.
  - eng_cmd_valid drops the following cycle.
  - The FSM then waits for eng_done.
  - eng_done arriving in the same cycle as eng_cmd_ready is legal and is consumed.
- States: IDLE, START, DEVW, REG, RESTART, DEVR, RDATA, WDATA, STOP, RESP.
- Write sequence: START, WRITE {dev,0}, WRITE reg, WRITE wdata[0..len-1], STOP.
- Read sequence: START, WRITE {dev,0}, WRITE reg, RESTART, WRITE {dev,1}, then len-1 × READ_ACK, 1 × READ_NACK, STOP.
  - Each eng_rdata is stored into rsp_data byte i at eng_done.
- req_len = 0: probe. Sequence is START, WRITE {dev,0}, STOP. The register byte is not sent; status reflects the address ACK.
- req_len > MAX_LEN: clamped to MAX_LEN.
- Error handling:
  - eng_nack on a device-address byte → STOP, status 01.
  - eng_nack on the register or payload byte → STOP, status 10; remaining bytes skipped.
  - eng_timeout on any command → RESP directly with no STOP, status 11.
  - Timeout has priority over NACK when both are flagged.
- RESP state:
  - rsp_valid pulses for 1 cycle with rsp_status.
  - rsp_data holds until the next accept; unread bytes are 0, cleared on accept.
  - Next cycle: IDLE, req_ready = 1, busy = 0.
- Minimum latency, accept to rsp_valid: 2 + commands × (engine time + 1) cycles.

Optional Feature:
- Macro: I2C_SEQ_RETRY_EN.
- With the macro: an address NACK (first or repeated address byte) issues STOP, then restarts the whole transaction from START.
  - Up to RETRY_MAX retries. The retry counter resets on accept.
  - Status 01 is reported only after retries are exhausted; data NACK and timeout are not retried.
- Without the macro: no retry; the first address NACK completes with status 01. RETRY_MAX is unused.

Test Plan:
- Write: dev 0x68, reg 0x0E, len 2, wdata 0x1C_00; engine ACKs everything → commands START, W 0xD0, W 0x0E, W 0x00, W 0x1C, STOP; rsp_status 00.
- Read: dev 0x68, reg 0x00, len 3; engine returns 0x45, 0x30, 0x12 → sequence ends RESTART, W 0xD1, RA, RA, RN, STOP; rsp_data[23:0] = 0x123045, status 00.
- Address NACK on W 0xD0 → STOP, status 01.
  - With I2C_SEQ_RETRY_EN and RETRY_MAX 3: 4 START commands before status 01.
  - Same bench with NACK only on the first attempt → status 00.
- Timeout on the second READ → no STOP command, status 11, rsp_data byte 0 valid, bytes 1–3 = 0.
- eng_cmd_ready held low 5 cycles → eng_cmd and eng_wdata stable throughout; req_valid pulsed while busy → ignored.
- Probe len 0 to dev 0x50, ACK → START, W 0xA0, STOP, status 00.
- reset_n asserted mid-read → next cycle: outputs at reset values, req_ready 1.
